// File: rtl/starflux_pkg.sv
// rtl/starflux_pkg.sv - shared types and screen constants for the starflux game blocks
package starflux_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_NEG  = 2'd1,
        DIR_POS  = 2'd2
    } dir_t;

    localparam int SCREEN_X_MAX = 120;
    localparam int SCREEN_Y_MAX = 100;
    localparam int TICK_16HZ    = 3_125_000;

    // Opposing keys cancel out rather than favouring one side.
    function automatic dir_t decode_dir(input logic neg, input logic pos);
        dir_t d;
        d = DIR_IDLE;
        if (neg && !pos) begin
            d = DIR_NEG;
        end else if (pos && !neg) begin
            d = DIR_POS;
        end
        return d;
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// rtl/axis_stepper.sv - one position axis with bounds saturation and hold-to-accelerate step doubling
module axis_stepper
    import starflux_pkg::*;
#(
    parameter int W           = 8,
    parameter int MIN         = 0,
    parameter int MAX         = 120,
    parameter int START       = 0,
    parameter int ACCEL_TICKS = 4,
    parameter int MAX_STEP    = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic         recenter,
    input  logic         freeze,
    input  logic         move_neg,
    input  logic         move_pos,
    output logic [W-1:0] position,
    output logic         at_min,
    output logic         at_max,
    output logic         changed
);

    localparam int HW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS + 1) : 1;
    localparam logic [W:0]    MIN_W   = (W+1)'(MIN);
    localparam logic [W:0]    MAX_W   = (W+1)'(MAX);
    localparam logic [W:0]    CEIL_W  = (W+1)'(MAX_STEP);
    localparam logic [W-1:0]  START_V = W'(START);
    localparam logic [W-1:0]  ONE     = W'(1);
    localparam logic [HW-1:0] ACCEL_V = HW'(ACCEL_TICKS);

    logic [W-1:0]  step;
    logic [HW-1:0] hold;
    dir_t          last_dir;

    logic [W-1:0]  pos_n;
    logic [W-1:0]  step_n;
    logic [HW-1:0] hold_n;
    dir_t          dir_n;

    dir_t          dir;
    logic          same_dir;
    logic [W-1:0]  base_step;
    logic [HW-1:0] hold_inc;
    logic [W:0]    pos_w;
    logic [W:0]    step_w;
    logic [W:0]    step_dbl;

    assign dir = decode_dir(move_neg, move_pos);

    always_comb begin
        pos_n    = position;
        step_n   = step;
        hold_n   = hold;
        dir_n    = last_dir;
        changed  = 1'b0;
        same_dir = (dir == last_dir) && (dir != DIR_IDLE);
        // A fresh direction counts as the first held tick at step 1.
        base_step = same_dir ? step : ONE;
        hold_inc  = (same_dir ? hold : '0) + 1'b1;
        pos_w     = {1'b0, position};
        step_w    = {1'b0, base_step};
        step_dbl  = step_w << 1;

        if (recenter) begin
            pos_n  = START_V;
            step_n = ONE;
            hold_n = '0;
            dir_n  = DIR_IDLE;
        end else if (freeze) begin
            step_n = ONE;
            hold_n = '0;
            dir_n  = DIR_IDLE;
        end else if (tick) begin
            if (dir == DIR_IDLE) begin
                step_n = ONE;
                hold_n = '0;
                dir_n  = DIR_IDLE;
            end else begin
                dir_n  = dir;
                step_n = base_step;
                hold_n = hold_inc;
                if ((ACCEL_TICKS != 0) && (hold_inc == ACCEL_V)) begin
                    step_n = (step_dbl > CEIL_W) ? CEIL_W[W-1:0] : step_dbl[W-1:0];
                    hold_n = '0;
                end
                // Bounds are checked in W+1 bits so the sum can never wrap.
                if (dir == DIR_NEG) begin
                    pos_n = (pos_w >= MIN_W + step_w) ? position - base_step : MIN_W[W-1:0];
                end else begin
                    pos_n = (pos_w + step_w <= MAX_W) ? position + base_step : MAX_W[W-1:0];
                end
                changed = (pos_n != position);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            position <= START_V;
            step     <= ONE;
            hold     <= '0;
            last_dir <= DIR_IDLE;
        end else begin
            position <= pos_n;
            step     <= step_n;
            hold     <= hold_n;
            last_dir <= dir_n;
        end
    end

    assign at_min = (position == MIN_W[W-1:0]);
    assign at_max = (position == MAX_W[W-1:0]);

endmodule

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running down-counter producing a one-cycle strobe every TICK_DIV clocks
module tick_divider #(
    parameter int TICK_DIV = 3_125_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= RELOAD;
        end else if (clear || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/ship_motion_ctrl.sv
// rtl/ship_motion_ctrl.sv - two-axis player-ship position controller with tick divider and acceleration
module ship_motion_ctrl
    import starflux_pkg::*;
#(
    parameter int W           = 8,
    parameter int TICK_DIV    = TICK_16HZ,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = SCREEN_X_MAX,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = SCREEN_Y_MAX,
    parameter int START_X     = 0,
    parameter int START_Y     = 100,
    parameter int ACCEL_TICKS = 4,
    parameter int MAX_STEP    = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         left,
    input  logic         right,
    input  logic         up,
    input  logic         down,
    input  logic         recenter,
    input  logic         freeze,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic [3:0]   at_edge,
    output logic         moved,
    output logic         tick
);

    logic x_at_min, x_at_max, x_changed;
    logic y_at_min, y_at_max, y_changed;

    // Recenter restarts the tick phase so a new game always begins on a full period.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .clear (recenter),
        .tick  (tick)
    );

    axis_stepper #(
        .W           (W),
        .MIN         (X_MIN),
        .MAX         (X_MAX),
        .START       (START_X),
        .ACCEL_TICKS (ACCEL_TICKS),
        .MAX_STEP    (MAX_STEP)
    ) u_axis_x (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .recenter (recenter),
        .freeze   (freeze),
        .move_neg (left),
        .move_pos (right),
        .position (pos_x),
        .at_min   (x_at_min),
        .at_max   (x_at_max),
        .changed  (x_changed)
    );

    axis_stepper #(
        .W           (W),
        .MIN         (Y_MIN),
        .MAX         (Y_MAX),
        .START       (START_Y),
        .ACCEL_TICKS (ACCEL_TICKS),
        .MAX_STEP    (MAX_STEP)
    ) u_axis_y (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .recenter (recenter),
        .freeze   (freeze),
        .move_neg (up),
        .move_pos (down),
        .position (pos_y),
        .at_min   (y_at_min),
        .at_max   (y_at_max),
        .changed  (y_changed)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            moved <= 1'b0;
        end else begin
            moved <= x_changed | y_changed;
        end
    end

    assign at_edge = {x_at_min, x_at_max, y_at_min, y_at_max};

endmodule
